muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution stage. Consumes the two source operands read from the register file and produces one 32-bit result for the register-file write-back path. Uses a start/busy/done handshake so the control unit can stall the pipeline during the fixed multi-cycle latency. One operation is in flight at a time.

---
 rtl/muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with sign correction applied after the iterations.
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONE      = XLEN'(1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state_reg, state_next;
    logic [5:0]      count_reg;
    logic [2:0]      op_reg;
    logic [4:0]      rd_reg;
    logic [XLEN-1:0] a_mag_reg, b_mag_reg;
    logic            a_neg_reg, b_neg_reg;
    logic [XLEN-1:0] hi_reg, lo_reg;
    logic [XLEN-1:0] fix_reg;
    logic [XLEN-1:0] result_reg;
    logic [4:0]      rd_out_reg;
    logic            done_reg;

    logic            accept;
    logic            a_signed, b_signed, a_neg_in, b_neg_in;
    logic [XLEN-1:0] a_mag_in, b_mag_in;

    always_comb begin
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg_in = a_signed & rs1_data[XLEN-1];
        b_neg_in = b_signed & rs2_data[XLEN-1];
        a_mag_in = a_neg_in ? -rs1_data : rs1_data;
        b_mag_in = b_neg_in ? -rs2_data : rs2_data;
        accept   = (state_reg == IDLE) && start && !kill;
    end

    // One iteration: hi:lo is the running product (multiplier in lo) or the
    // partial remainder:dividend pair whose low half collects quotient bits.
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN-1:0] div_diff;
    logic            div_ok;

    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_mag_reg} : '0);
        div_shift = {hi_reg, lo_reg[XLEN-1]};
        div_ok    = (div_shift >= {1'b0, b_mag_reg});
        div_diff  = div_shift[XLEN-1:0] - b_mag_reg;
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, a_orig, fix_next;
    logic              res_neg, b_zero, ovf;

    always_comb begin
        res_neg  = a_neg_reg ^ b_neg_reg;
        prod_fix = res_neg ? -{hi_reg, lo_reg} : {hi_reg, lo_reg};
        quo_fix  = res_neg ? -lo_reg : lo_reg;
        rem_fix  = a_neg_reg ? -hi_reg : hi_reg;
        a_orig   = a_neg_reg ? -a_mag_reg : a_mag_reg;
        b_zero   = (b_mag_reg == '0);
        // Only the signed ops can set both sign flags, so this excludes DIVU/REMU.
        ovf      = a_neg_reg && b_neg_reg && (a_mag_reg == MIN_NEG) && (b_mag_reg == ONE);
        case (op_reg)
            3'b000:                 fix_next = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_next = prod_fix[2*XLEN-1:XLEN];
            3'b100:                 fix_next = b_zero ? ALL_ONES : (ovf ? MIN_NEG : quo_fix);
            3'b101:                 fix_next = b_zero ? ALL_ONES : lo_reg;
            3'b110:                 fix_next = b_zero ? a_orig : (ovf ? '0 : rem_fix);
            default:                fix_next = b_zero ? a_mag_reg : hi_reg;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = CALC;
            CALC: begin
                if (kill)
                    state_next = IDLE;
                else if (count_reg == 6'(ITER - 1))
                    state_next = FIX;
            end
            FIX:  state_next = kill ? IDLE : DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg  <= '0;
            op_reg     <= '0;
            rd_reg     <= '0;
            a_mag_reg  <= '0;
            b_mag_reg  <= '0;
            a_neg_reg  <= 1'b0;
            b_neg_reg  <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            fix_reg    <= '0;
            result_reg <= '0;
            rd_out_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg    <= funct3;
                        rd_reg    <= rd_in;
                        a_mag_reg <= a_mag_in;
                        b_mag_reg <= b_mag_in;
                        a_neg_reg <= a_neg_in;
                        b_neg_reg <= b_neg_in;
                        count_reg <= '0;
                        hi_reg    <= '0;
                        lo_reg    <= funct3[2] ? a_mag_in : b_mag_in;
                    end
                end
                CALC: begin
                    count_reg <= count_reg + 6'd1;
                    if (op_reg[2]) begin
                        hi_reg <= div_ok ? div_diff : div_shift[XLEN-1:0];
                        lo_reg <= {lo_reg[XLEN-2:0], div_ok};
                    end else begin
                        hi_reg <= mul_sum[XLEN:1];
                        lo_reg <= {mul_sum[0], lo_reg[XLEN-1:1]};
                    end
                end
                FIX: fix_reg <= fix_next;
                DONE: begin
                    result_reg <= fix_reg;
                    rd_out_reg <= rd_reg;
                    done_reg   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The done pulse is registered out of DONE, so busy stays high through it.
    assign busy   = (state_reg != IDLE) || done_reg;
    assign done   = done_reg;
    assign result = result_reg;
    assign rd_out = rd_out_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: hand-computed RV32M results, latency,
// busy window, start-while-busy, kill and mid-operation reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, start, kill;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data;
    logic [4:0]  rd_in;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .kill     (kill),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_in    (rd_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .rd_out   (rd_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one operation, scramble the inputs right after the start edge (E0),
    // then watch busy/done. Samples are taken 1ns after each edge: sample i
    // follows edge E_i, so done is expected at i=34 and busy for i=0..34.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        int          busy_cnt;
        int          dones;
        int          done_at;
        logic [31:0] res_seen;
        logic [4:0]  rd_seen;
        busy_cnt = 0;
        dones    = 0;
        done_at  = -1;
        res_seen = '0;
        rd_seen  = '0;
        @(negedge clk);
        funct3   = f3;
        rs1_data = a;
        rs2_data = b;
        rd_in    = rd;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        funct3   = ~f3;
        rs1_data = ~a;
        rs2_data = b + 32'd1;
        rd_in    = ~rd;
        for (int i = 0; i < 60; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                dones++;
                done_at  = i;
                res_seen = result;
                rd_seen  = rd_out;
            end
            if (!busy) break;
            @(posedge clk);
            #1;
        end
        $display("op %s f3=%b a=%h b=%h rd=%0d -> result=%h rd_out=%0d done_at=%0d busy_cycles=%0d",
                 tag, f3, a, b, rd, res_seen, rd_seen, done_at, busy_cnt);
        chk({tag, " latency"}, done_at, 34);
        chk({tag, " done_pulses"}, dones, 1);
        chk({tag, " busy_cycles"}, busy_cnt, 35);
        chk({tag, " result"}, res_seen, exp);
        chk({tag, " rd_out"}, {27'b0, rd_seen}, {27'b0, rd});
    endtask

    initial begin
        int          dones;
        int          done_at;
        logic [31:0] res_seen;
        logic [4:0]  rd_seen;

        reset    = 1'b1;
        start    = 1'b0;
        kill     = 1'b0;
        funct3   = 3'b000;
        rs1_data = '0;
        rs2_data = '0;
        rd_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset rd_out", {27'b0, rd_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("MUL 7x6",        3'b000, 32'd7,        32'd6,        5'd5,  32'h0000_002A);
        run_op("MULH -1x-1",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000);
        run_op("MUL -1x-1",      3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0001);
        run_op("MULHU max",      3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE);
        run_op("MULHSU -1x2",    3'b010, 32'hFFFF_FFFF, 32'd2,        5'd4,  32'hFFFF_FFFF);
        run_op("DIV -7/2",       3'b100, 32'hFFFF_FFF9, 32'd2,        5'd6,  32'hFFFF_FFFD);
        run_op("REM -7/2",       3'b110, 32'hFFFF_FFF9, 32'd2,        5'd7,  32'hFFFF_FFFF);
        run_op("DIVU big/2",     3'b101, 32'hFFFF_FFF9, 32'd2,        5'd8,  32'h7FFF_FFFC);
        run_op("REMU big/2",     3'b111, 32'hFFFF_FFF9, 32'd2,        5'd9,  32'h0000_0001);
        run_op("DIVU 100/0",     3'b101, 32'd100,      32'd0,        5'd10, 32'hFFFF_FFFF);
        run_op("REMU 100/0",     3'b111, 32'd100,      32'd0,        5'd11, 32'd100);
        run_op("REM -7/0",       3'b110, 32'hFFFF_FFF9, 32'd0,        5'd12, 32'hFFFF_FFF9);
        run_op("DIV ovf",        3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
        run_op("REM ovf",        3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000);

        // start held high for a whole operation: one done, operands frozen at E0
        @(negedge clk);
        funct3   = 3'b000;
        rs1_data = 32'd5;
        rs2_data = 32'd5;
        rd_in    = 5'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        rs1_data = 32'd9;
        rd_in    = 5'd4;
        dones    = 0;
        done_at  = -1;
        res_seen = '0;
        rd_seen  = '0;
        for (int i = 0; i < 36; i++) begin
            if (done) begin
                dones++;
                done_at  = i;
                res_seen = result;
                rd_seen  = rd_out;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        $display("op HOLD MUL 5x5 -> result=%h rd_out=%0d done_at=%0d pulses=%0d",
                 res_seen, rd_seen, done_at, dones);
        chk("hold done_pulses", dones, 1);
        chk("hold latency", done_at, 34);
        chk("hold result", res_seen, 32'h0000_0019);
        chk("hold rd_out", {27'b0, rd_seen}, 32'd3);
        dones = 0;
        for (int i = 0; i < 80; i++) begin
            if (done) begin
                dones++;
                res_seen = result;
                rd_seen  = rd_out;
            end
            if (!busy) break;
            @(posedge clk);
            #1;
        end
        $display("op HOLD second MUL 9x5 -> result=%h rd_out=%0d pulses=%0d", res_seen, rd_seen, dones);
        chk("hold2 done_pulses", dones, 1);
        chk("hold2 result", res_seen, 32'h0000_002D);
        chk("hold2 rd_out", {27'b0, rd_seen}, 32'd4);

        // kill sampled at E10
        @(negedge clk);
        funct3   = 3'b101;
        rs1_data = 32'd1000;
        rs2_data = 32'd3;
        rd_in    = 5'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kill busy", {31'b0, busy}, 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            @(posedge clk);
            #1;
        end
        $display("op KILL DIVU 1000/3 -> result=%h rd_out=%0d pulses=%0d", result, rd_out, dones);
        chk("kill done_pulses", dones, 0);
        chk("kill result_held", result, 32'h0000_002D);
        chk("kill rd_held", {27'b0, rd_out}, 32'd4);
        run_op("MUL 3x3 after kill", 3'b000, 32'd3, 32'd3, 5'd8, 32'd9);

        // reset sampled at E20
        @(negedge clk);
        funct3   = 3'b011;
        rs1_data = 32'hFFFF_0000;
        rs2_data = 32'h0001_2345;
        rd_in    = 5'd9;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midreset busy", {31'b0, busy}, 32'd0);
        chk("midreset done", {31'b0, done}, 32'd0);
        chk("midreset result", result, 32'd0);
        chk("midreset rd_out", {27'b0, rd_out}, 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            @(posedge clk);
            #1;
        end
        $display("op RESET MULHU at E20 -> result=%h rd_out=%0d pulses=%0d", result, rd_out, dones);
        chk("midreset done_pulses", dones, 0);
        chk("midreset idle", {31'b0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
